// File: rtl/flash_prefetch_buf.sv
// Single-line read prefetch buffer between the CPU Wishbone bus and the flash controller.
// Hits answer in one cycle; misses burst-fill the whole line over the master port first.
module flash_prefetch_buf #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 24
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        inval_i
);
  localparam int IW = $clog2(LINE_WORDS);
  localparam int TW = ADDR_W - IW - 2;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RESP, S_ERR} state_t;

  state_t        r_state;
  logic          r_valid;
  logic          r_inv_pend;
  logic          r_ack;
  logic          r_err;
  logic [TW-1:0] r_tag;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] r_cnt;
  logic [31:0]   r_dat;
  logic [31:0]   r_buf [LINE_WORDS];

  logic          w_req;
  logic [TW-1:0] w_tag;
  logic [IW-1:0] w_idx;
  logic          w_hit;
  logic          w_last;
  logic          w_unused_in;

  assign w_req  = wbs_cyc_i & wbs_stb_i;
  assign w_tag  = wbs_adr_i[ADDR_W-1:IW+2];
  assign w_idx  = wbs_adr_i[IW+1:2];
  // An invalidate arriving with the request wins over the hit.
  assign w_hit  = r_valid & ~inval_i & (w_tag == r_tag);
  assign w_last = (r_cnt == IW'(LINE_WORDS - 1));
  assign w_unused_in = ^{wbs_sel_i, wbs_dat_i, wbs_adr_i[31:ADDR_W], wbs_adr_i[1:0]};

  assign wbs_dat_o = r_dat;
  assign wbs_ack_o = r_ack;
  assign wbs_err_o = r_err;
  assign wbm_cyc_o = (r_state == S_FILL);
  assign wbm_stb_o = (r_state == S_FILL);
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = 4'hF;
  assign wbm_adr_o = (r_state == S_FILL) ? {{(32-ADDR_W){1'b0}}, r_tag, r_cnt, 2'b00} : 32'h0;

  always_ff @(posedge wb_clk_i) begin
    if (r_state == S_FILL && wbm_ack_i && !wbm_err_i)
      r_buf[r_cnt] <= wbm_dat_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_state    <= S_IDLE;
      r_valid    <= 1'b0;
      r_inv_pend <= 1'b0;
      r_cnt      <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_dat      <= 32'h0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (inval_i)
            r_valid <= 1'b0;
          if (w_req) begin
            if (wbs_we_i) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else if (w_hit) begin
              r_state <= S_RESP;
              r_ack   <= 1'b1;
              r_dat   <= r_buf[w_idx];
            end else begin
              r_state    <= S_FILL;
              r_cnt      <= '0;
              r_valid    <= 1'b0;
              r_tag      <= w_tag;
              r_idx      <= w_idx;
              r_inv_pend <= 1'b0;
            end
          end
        end
        S_FILL: begin
          // Invalidates seen mid-fill are remembered and applied when the line completes.
          if (inval_i)
            r_inv_pend <= 1'b1;
          if (wbm_err_i) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
            r_valid <= 1'b0;
            r_cnt   <= '0;
          end else if (wbm_ack_i) begin
            if (r_cnt == r_idx)
              r_dat <= wbm_dat_i;
            if (w_last) begin
              r_valid <= ~(r_inv_pend | inval_i);
              r_state <= S_RESP;
              r_ack   <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          if (inval_i)
            r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_flash_prefetch_buf.sv
// Directed bench for flash_prefetch_buf with a small flash responder model
// (data = 0xF000_0000 | address, programmable wait states and error address).
module tb_flash_prefetch_buf;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0, inval = 1'b0;
  logic [31:0] s_adr = 32'h0;
  logic [31:0] s_dat_o, m_adr, m_dat;
  logic        s_ack, s_err, m_cyc, m_stb, m_we, m_ack, m_err;
  logic [3:0]  m_sel;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wait_adr = 32'hFFFF_FFFF;
  int          wait_n   = 0;
  int          wcnt     = 0;
  logic [31:0] err_adr  = 32'hFFFF_FFFF;
  logic [31:0] stb_q[$];
  logic [31:0] ack_q[$];

  always #5 clk = ~clk;

  flash_prefetch_buf dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .wbs_cyc_i(s_cyc), .wbs_stb_i(s_stb), .wbs_we_i(s_we), .wbs_adr_i(s_adr),
    .wbs_sel_i(4'hF), .wbs_dat_i(32'h0),
    .wbs_dat_o(s_dat_o), .wbs_ack_o(s_ack), .wbs_err_o(s_err),
    .wbm_cyc_o(m_cyc), .wbm_stb_o(m_stb), .wbm_we_o(m_we), .wbm_sel_o(m_sel),
    .wbm_adr_o(m_adr), .wbm_dat_i(m_dat), .wbm_ack_i(m_ack), .wbm_err_i(m_err),
    .inval_i(inval)
  );

  assign m_ack = m_stb && !(m_adr == wait_adr && wcnt < wait_n);
  assign m_err = m_stb && (m_adr == err_adr);
  assign m_dat = 32'hF000_0000 | m_adr;

  always @(posedge clk) begin
    if (m_stb) stb_q.push_back(m_adr);
    if (m_stb && m_ack && !m_err) ack_q.push_back(m_adr);
    if (m_stb && m_adr == wait_adr) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request; lat is the cycle (request sampled in cycle 0) in which ack/err appears.
  task automatic access(input string tag, input logic [31:0] a, input logic w, input int inv_at,
                        output int lat, output logic ack, output logic err, output logic [31:0] dat);
    @(posedge clk); #1;
    s_adr = a; s_we = w; s_cyc = 1'b1; s_stb = 1'b1; inval = (inv_at == 0);
    @(posedge clk); #1;
    s_cyc = 1'b0; s_stb = 1'b0; lat = 1; inval = (inv_at == 1);
    while (!(s_ack || s_err) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      inval = (inv_at == lat);
    end
    inval = 1'b0;
    ack = s_ack; err = s_err; dat = s_dat_o;
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, {30'b0, s_ack, s_err}, 32'h0);
  endtask

  task automatic check_fill(input string tag, input int base_idx, input logic [31:0] line);
    check({tag, "_nwords"}, ack_q.size() - base_idx, 4);
    for (int i = 0; i < 4; i++)
      if (base_idx + i < ack_q.size())
        check({tag, "_madr"}, ack_q[base_idx + i], line + 32'(4 * i));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack"}, {31'b0, s_ack}, 32'h0);
    check({tag, "_err"}, {31'b0, s_err}, 32'h0);
    check({tag, "_mcyc_mstb"}, {30'b0, m_cyc, m_stb}, 32'h0);
    check({tag, "_madr"}, m_adr, 32'h0);
    check({tag, "_dat"}, s_dat_o, 32'h0);
  endtask

  initial begin
    int lat, b, sb, hold;
    logic ack, err;
    logic [31:0] dat;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    check("rst_we_sel", {27'b0, m_we, m_sel}, 32'h0000_000F);
    rst_n = 1'b1;

    // Cold miss, zero-wait flash
    b = ack_q.size();
    access("miss104", 32'h0000_0104, 1'b0, -1, lat, ack, err, dat);
    check("miss104_lat", lat, 5);
    check("miss104_ackerr", {30'b0, ack, err}, 32'h2);
    check("miss104_dat", dat, 32'hF000_0104);
    check_fill("miss104", b, 32'h0000_0100);

    // Hit on same line
    sb = stb_q.size();
    access("hit10C", 32'h0000_010C, 1'b0, -1, lat, ack, err, dat);
    check("hit10C_lat", lat, 1);
    check("hit10C_dat", dat, 32'hF000_010C);
    check("hit10C_nostb", stb_q.size() - sb, 0);

    // Miss with two wait states on word 2
    wait_adr = 32'h0000_0208; wait_n = 2;
    b = ack_q.size(); sb = stb_q.size();
    access("wait200", 32'h0000_0200, 1'b0, -1, lat, ack, err, dat);
    wait_adr = 32'hFFFF_FFFF; wait_n = 0;
    check("wait200_lat", lat, 7);
    check("wait200_dat", dat, 32'hF000_0200);
    check_fill("wait200", b, 32'h0000_0200);
    hold = 0;
    for (int i = sb; i < stb_q.size(); i++)
      if (stb_q[i] == 32'h0000_0208) hold++;
    check("wait200_hold208", hold, 3);
    access("hit204", 32'h0000_0204, 1'b0, -1, lat, ack, err, dat);
    check("hit204_lat", lat, 1);
    check("hit204_dat", dat, 32'hF000_0204);

    // Write is rejected, line untouched
    sb = stb_q.size();
    access("wr200", 32'h0000_0200, 1'b1, -1, lat, ack, err, dat);
    check("wr200_lat", lat, 1);
    check("wr200_ackerr", {30'b0, ack, err}, 32'h1);
    check("wr200_nostb", stb_q.size() - sb, 0);
    access("rehit200", 32'h0000_0200, 1'b0, -1, lat, ack, err, dat);
    check("rehit200_lat", lat, 1);
    check("rehit200_dat", dat, 32'hF000_0200);

    // Address bits above ADDR_W alias onto the same line
    access("alias", 32'h7F00_020C, 1'b0, -1, lat, ack, err, dat);
    check("alias_lat", lat, 1);
    check("alias_dat", dat, 32'hF000_020C);

    // Flash error on word 1
    err_adr = 32'h0030_0004;
    b = ack_q.size();
    access("ferr", 32'h0030_0000, 1'b0, -1, lat, ack, err, dat);
    err_adr = 32'hFFFF_FFFF;
    check("ferr_ackerr", {30'b0, ack, err}, 32'h1);
    check("ferr_lat", lat, 3);
    check("ferr_nwords", ack_q.size() - b, 1);
    b = ack_q.size();
    access("refill", 32'h0030_0000, 1'b0, -1, lat, ack, err, dat);
    check("refill_lat", lat, 5);
    check("refill_dat", dat, 32'hF030_0000);
    check_fill("refill", b, 32'h0030_0000);

    // Reset in the middle of a fill
    @(posedge clk); #1;
    s_adr = 32'h0000_0504; s_we = 1'b0; s_cyc = 1'b1; s_stb = 1'b1;
    @(posedge clk); #1;
    s_cyc = 1'b0; s_stb = 1'b0;
    @(posedge clk); #1;
    check("midfill_stb", {31'b0, m_stb}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("midrst");
    @(posedge clk); #1;
    check_idle_outputs("midrst2");
    rst_n = 1'b1;
    b = ack_q.size();
    access("postrst", 32'h0000_0104, 1'b0, -1, lat, ack, err, dat);
    check("postrst_lat", lat, 5);
    check("postrst_dat", dat, 32'hF000_0104);
    check_fill("postrst", b, 32'h0000_0100);

    // Invalidate during a fill: response delivered, line not kept
    access("invfill", 32'h0000_0400, 1'b0, 2, lat, ack, err, dat);
    check("invfill_lat", lat, 5);
    check("invfill_dat", dat, 32'hF000_0400);
    b = ack_q.size();
    access("invmiss", 32'h0000_0404, 1'b0, -1, lat, ack, err, dat);
    check("invmiss_lat", lat, 5);
    check("invmiss_dat", dat, 32'hF000_0404);
    check_fill("invmiss", b, 32'h0000_0400);

    // Invalidate together with an otherwise-hitting request forces a miss
    access("invidle", 32'h0000_0408, 1'b0, 0, lat, ack, err, dat);
    check("invidle_lat", lat, 5);
    check("invidle_dat", dat, 32'hF000_0408);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
